next_pc_unit: RTL
=================

# next_pc_unit

Parametrised next-PC stage of the single-cycle datapath, replacing the fixed PC+4 / branch-target select with a full PC register and redirect logic. It evaluates all six conditional-branch conditions from ALU flags and supports JAL and JALR targets. It also adds stall hold, misaligned-target halt, and branch statistics counters. It sits between the control unit/ALU and the instruction memory address port.

## Interface
Parameters:
- XLEN, 32, datapath and PC width (≥ 8)
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4
- CNT_W, 32, width of the statistics counters

Ports (clock and reset first):
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and all state this cycle
- branch  in  1  current instruction is a conditional branch
- jump  in  1  current instruction is JAL
- jalr  in  1  current instruction is JALR
- funct3  in  3  branch condition select
- alu_zero  in  1  rs1 == rs2
- alu_lt  in  1  rs1 < rs2, signed
- alu_ltu  in  1  rs1 < rs2, unsigned
- imm  in  XLEN  sign-extended immediate, byte offset
- rs1_val  in  XLEN  JALR base register value
- pc  out  XLEN  current PC, registered
- pc_plus4  out  XLEN  pc + 4, combinational; this is the link value
- next_pc  out  XLEN  value PC loads at the next non-stalled edge, combinational
- redirect  out  1  registered; high for one cycle after PC loaded a non-sequential target
- halted  out  1  registered; unit is in HALT
- branch_cnt  out  CNT_W  conditional branches retired
- taken_cnt  out  CNT_W  conditional branches taken

## Operation
Branch condition, by funct3:
- 000 → alu_zero
- 001 → !alu_zero
- 100 → alu_lt
- 101 → !alu_lt
- 110 → alu_ltu
- 111 → !alu_ltu
- 010, 011 → never taken

Target selection (taken = branch & condition), first match wins:
- jalr → (rs1_val + imm) with bit 0 cleared
- jump → pc + imm
- taken → pc + imm
- otherwise → pc_plus4

Arithmetic rules:
- All additions are modulo 2^XLEN, so wrap-around is silent.
- imm is treated as already sign-extended.

Non-sequential selection:
- The selected target is "non-sequential" when any of jalr, jump or taken is active.
- A non-sequential target is "misaligned" when target[1:0] != 00.

State machine, two states: RUN and HALT.
- RUN, rst=0, stall=0, target aligned:
  - pc ← next_pc
  - redirect ← non-sequential
  - branch_cnt increments if branch
  - taken_cnt increments if taken
- RUN, stall=1: pc, counters and state are held; redirect ← 0; no misalignment check.
- RUN, stall=0, misaligned:
  - go to HALT; pc is held at the faulting instruction
  - redirect ← 0; halted ← 1
  - counters are not updated
- HALT: pc and counters are frozen, halted=1, redirect=0. All inputs are ignored. HALT exits only via rst.
- While halted, next_pc reads as pc.

Simultaneous inputs:
- branch with jump or jalr: the jump wins; the branch counters still count the branch and its taken status.
- jump with jalr: jalr wins.

Counters wrap to 0 after 2^CNT_W − 1.

## Timing
- Reset (rst=1 at an edge; rst overrides stall and HALT):
  - pc = RESET_PC
  - redirect = 0, halted = 0
  - branch_cnt = 0, taken_cnt = 0
  - state = RUN
- Reset mid-operation takes effect at the same edge and discards any pending update.
- Latency from control/flag inputs:
  - next_pc follows them with zero cycles (combinational).
  - pc reflects them one cycle later.
  - redirect is asserted in the same cycle that pc shows the new target.
- redirect is a single-cycle pulse per non-sequential update. Back-to-back taken branches give consecutive high cycles.
- After stall deasserts, the update uses the inputs present in that cycle; no input is buffered across a stall.
- halted rises on the edge following the misaligned cycle and stays high until reset.

## Test plan
- Reset then sequential run: rst for 2 cycles with RESET_PC=0x100, then 3 idle cycles. Required: pc is 0x100, 0x104, 0x108, 0x10C; redirect stays 0; both counters stay 0.
- All six branch conditions: at pc=0x200 with imm=0x20, drive each funct3 with the flag taken and then not taken. Required:
  - taken cases: pc=0x220 and redirect=1 next cycle
  - not-taken cases: pc=0x204
  - after the 12 branches: branch_cnt=12, taken_cnt=6
  - funct3=010 is never taken
- JALR and priority: rs1_val=0x1001, imm=0x3, with jalr, jump and a taken branch all set. Required: pc=0x1004, redirect=1, and pc_plus4 was the old pc+4 in the prior cycle.
- Stall: hold stall=1 for 3 cycles with a taken branch driven. Required: pc unchanged, redirect=0, counters unchanged. The cycle after release takes the branch.
- Misaligned halt: pc=0x300, jump with imm=0x6. Required:
  - next edge: halted=1 and pc=0x300
  - 5 further jumps: no change
  - rst: pc=RESET_PC and halted=0
- Wrap and counter overflow: CNT_W=4 with 17 branches gives branch_cnt=1. pc=0xFFFFFFFC with no jump gives next pc=0x00000000.

Source files
------------

// File: rtl/next_pc_unit_if.sv
// Handshake-free control/flag bundle between decode/ALU and the next-PC stage.
// The master drives control and flags; the slave is the next-PC unit.
interface next_pc_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             branch;
    logic             jump;
    logic             jalr;
    logic [2:0]       funct3;
    logic             alu_zero;
    logic             alu_lt;
    logic             alu_ltu;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  next_pc;
    logic             redirect;
    logic             halted;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, branch, jump, jalr, funct3,
        output alu_zero, alu_lt, alu_ltu, imm, rs1_val,
        input  pc, pc_plus4, next_pc, redirect, halted,
        input  branch_cnt, taken_cnt
    );

    modport slave (
        input  stall, branch, jump, jalr, funct3,
        input  alu_zero, alu_lt, alu_ltu, imm, rs1_val,
        output pc, pc_plus4, next_pc, redirect, halted,
        output branch_cnt, taken_cnt
    );
endinterface

// File: rtl/next_pc_unit.sv
// PC register with branch/jump redirect, stall hold, misaligned-target halt
// and branch statistics counters.
module next_pc_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    CNT_W    = 32
) (
    input logic           clk,
    input logic           rst,
    next_pc_unit_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t           state, state_nx;
    logic [XLEN-1:0]  pc_q, pc_nx;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;
    logic             redirect_q, redirect_nx;
    logic [CNT_W-1:0] bcnt_q, bcnt_nx;
    logic [CNT_W-1:0] tcnt_q, tcnt_nx;
    logic             cond, taken, non_seq, misaligned;

    always_comb begin
        cond = 1'b0;
        case (bus.funct3)
            3'b000:  cond = bus.alu_zero;
            3'b001:  cond = !bus.alu_zero;
            3'b100:  cond = bus.alu_lt;
            3'b101:  cond = !bus.alu_lt;
            3'b110:  cond = bus.alu_ltu;
            3'b111:  cond = !bus.alu_ltu;
            default: cond = 1'b0;
        endcase
    end

    assign taken    = bus.branch & cond;
    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = bus.rs1_val + bus.imm;

    always_comb begin
        target = pc_plus4;
        if (bus.jalr)
            target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
        else if (bus.jump || taken)
            target = pc_q + bus.imm;
    end

    assign non_seq    = bus.jalr | bus.jump | taken;
    assign misaligned = non_seq & (target[1:0] != 2'b00);

    // Branch counters still see a branch that a jump overrode.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc_q;
        redirect_nx = 1'b0;
        bcnt_nx     = bcnt_q;
        tcnt_nx     = tcnt_q;
        if (state == RUN && !bus.stall) begin
            if (misaligned) begin
                state_nx = HALT;
            end else begin
                pc_nx       = target;
                redirect_nx = non_seq;
                if (bus.branch)
                    bcnt_nx = bcnt_q + CNT_W'(1);
                if (taken)
                    tcnt_nx = tcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            state      <= state_nx;
            pc_q       <= pc_nx;
            redirect_q <= redirect_nx;
            bcnt_q     <= bcnt_nx;
            tcnt_q     <= tcnt_nx;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.next_pc    = (state == HALT) ? pc_q : target;
    assign bus.redirect   = redirect_q;
    assign bus.halted     = (state == HALT);
    assign bus.branch_cnt = bcnt_q;
    assign bus.taken_cnt  = tcnt_q;
endmodule
